// File: rtl/prog_loader.sv
// Boot loader: parses a framed valid/ready word stream into per-memory sections,
// writes each section from address 0, and holds the core in reset until the image is in.
module prog_loader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int NUM_MEM  = 2,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [DATA_W-1:0]  IN_DATA,
    input  logic               IN_LAST,
    output logic [NUM_MEM-1:0] MEM_WE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [DATA_W-1:0]  MEM_WDATA,
    output logic               CORE_RESET_N,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERROR,
    output logic [CNT_W-1:0]   WORD_COUNT
);

    localparam int HC_W = $clog2(HOLD_CYC + 1) + 1;
    localparam logic [ADDR_W:0] ONE_A = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state, state_next;
    logic [HC_W-1:0]   hold_cnt;
    logic [7:0]        sel_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   addr_q;
    logic              accept;
    logic              start_ok;
    logic              sec_last;
    logic [7:0]        hdr_sel;
    logic [ADDR_W:0]   hdr_len;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign IN_READY = (state == S_HDR) || (state == S_DATA);
    assign BUSY     = (state == S_HDR) || (state == S_DATA) || (state == S_HOLD);
    assign DONE     = (state == S_RUN);
    assign ERROR    = (state == S_ERR);

    assign accept   = IN_VALID && IN_READY;
    assign start_ok = START && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
    assign hdr_sel  = IN_DATA[DATA_W-1 -: 8];
    // LEN is carried one bit wider so a full 2^ADDR_W section does not wrap to zero
    assign hdr_len  = {1'b0, IN_DATA[ADDR_W-1:0]} + ONE_A;
    assign sec_last = (addr_q + ONE_A) == len_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (START) state_next = S_HDR;
            S_HDR: begin
                if (accept) begin
                    if ((hdr_sel >= 8'(NUM_MEM)) || IN_LAST) state_next = S_ERR;
                    else                                      state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (sec_last)     state_next = IN_LAST ? S_HOLD : S_HDR;
                    else if (IN_LAST) state_next = S_ERR;
                end
            end
            S_HOLD: if (hold_cnt == HC_W'(HOLD_CYC)) state_next = S_RUN;
            S_RUN:  if (START) state_next = S_HDR;
            S_ERR:  if (START) state_next = S_HDR;
            default: state_next = S_IDLE;
        endcase
    end

    // ---- stage p1: registered control, write port and status ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            MEM_WE       <= '0;
            MEM_ADDR     <= '0;
            MEM_WDATA    <= '0;
            WORD_COUNT   <= '0;
            CORE_RESET_N <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= (state == S_HOLD) ? hold_cnt + HC_W'(1) : '0;
            CORE_RESET_N <= (state_next == S_RUN);
            MEM_WE       <= '0;
            if ((state == S_DATA) && accept) begin
                MEM_WE     <= NUM_MEM'(1) << sel_q;
                MEM_ADDR   <= addr_q[ADDR_W-1:0];
                MEM_WDATA  <= IN_DATA;
                WORD_COUNT <= sat_inc(WORD_COUNT);
            end else if (start_ok) begin
                WORD_COUNT <= '0;
            end
        end
    end

    // Section bookkeeping is always reloaded by a header before use, so it needs no reset
    always_ff @(posedge CLK) begin
        if ((state == S_HDR) && accept) begin
            sel_q  <= hdr_sel;
            len_q  <= hdr_len;
            addr_q <= '0;
        end else if ((state == S_DATA) && accept) begin
            addr_q <= addr_q + ONE_A;
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Synthesisable boot loader for the single-cycle RISC-V system.
- Takes a framed word stream on a valid/ready interface and writes each section into one of NUM_MEM target memories, e.g. instruction ROM at index 0 and data RAM at index 1.
- Holds the core in reset during loading, then releases it.
- Replaces hierarchical $readmemh preloading with a real load path that the bench and the FPGA top can share.

Parameters:
- DATA_W, 32, stream and memory word width; must be at least ADDR_W+8.
- ADDR_W, 10, memory word-address width; a section holds at most 2^ADDR_W words.
- NUM_MEM, 2, number of target memories; range 1..255.
- HOLD_CYC, 4, cycles CORE_RESET_N stays low after the load completes; must be at least 1.
- CNT_W, 16, width of WORD_COUNT.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle load request.
- IN_VALID  in  1  stream word valid.
- IN_READY  out  1  loader accepts a word.
- IN_DATA  in  DATA_W  stream word.
- IN_LAST  in  1  marks the final word of the whole image.
- MEM_WE  out  NUM_MEM  one-hot write enable.
- MEM_ADDR  out  ADDR_W  write word address.
- MEM_WDATA  out  DATA_W  write data.
- CORE_RESET_N  out  1  active-low reset to the core.
- BUSY  out  1  high in HDR, DATA and HOLD.
- DONE  out  1  high in RUN.
- ERROR  out  1  high in ERR.
- WORD_COUNT  out  CNT_W  payload words written since the last START.

Behaviour:
- Reset: RESET is asynchronous and active-high. It forces state IDLE and sets every output to 0, including CORE_RESET_N=0 and WORD_COUNT=0. Reset mid-load abandons the load; no further MEM_WE occurs.
- Handshake: a word transfers when IN_VALID and IN_READY are both high on a rising edge. IN_READY is 1 only in HDR and DATA and depends on state only. The producer holds IN_DATA and IN_LAST while IN_VALID=1 and IN_READY=0.
- Frame format: a header word, then payload words.
  - Header bits [DATA_W-1:DATA_W-8] = SEL, the memory index.
  - Header bits [ADDR_W-1:0] = LEN-1, so LEN is 1..2^ADDR_W.
  - Other header bits are ignored.
  - Payload word k of a section goes to address k.
- States:
  - IDLE: CORE_RESET_N=0. START -> HDR.
  - HDR: on accept of a header:
    - SEL>=NUM_MEM -> ERR.
    - IN_LAST=1 -> ERR.
    - Otherwise latch SEL and LEN, clear the address -> DATA.
  - DATA: each accepted word is written.
    - Last word of the section with IN_LAST=1 -> HOLD.
    - Last word with IN_LAST=0 -> HDR.
    - IN_LAST=1 before the section's last word: the word is still written, then -> ERR.
  - HOLD: count HOLD_CYC cycles with CORE_RESET_N=0, then -> RUN.
  - RUN: CORE_RESET_N=1, DONE=1. START -> HDR, with CORE_RESET_N=0 from the next cycle.
  - ERR: ERROR=1, CORE_RESET_N=0. START -> HDR and clears ERROR.
- START is ignored in HDR, DATA and HOLD.
- START in IDLE, RUN or ERR clears WORD_COUNT.
- Write timing: MEM_WE, MEM_ADDR and MEM_WDATA are registered. They are valid in the cycle after the accepting edge, and MEM_WE is a single-cycle one-hot pulse per word. MEM_ADDR and MEM_WDATA hold their last value when MEM_WE=0.
- Address arithmetic: the section address counter is ADDR_W+1 bits internally, so LEN=2^ADDR_W ends at address 2^ADDR_W-1 without aliasing.
- WORD_COUNT increments once per payload write and saturates at 2^CNT_W-1.
- Back-to-back: a full-rate stream (IN_VALID held high) loads one word per cycle with no bubbles, including across section boundaries.
- Latency from the final accept to CORE_RESET_N rising is HOLD_CYC+1 cycles.

Test Plan:
- Basic load: START, header 0x00000002 (SEL=0, LEN=3), words 0xA,0xB,0xC with IN_LAST on 0xC -> MEM_WE=01 at addresses 0,1,2 with data A,B,C. WORD_COUNT=3. CORE_RESET_N rises 5 cycles after the last accept, and DONE=1.
- Two sections with IN_VALID toggling every cycle: SEL=0 LEN=2, then SEL=1 LEN=1 with IN_LAST -> MEM_WE pulses 01,01,10 at addresses 0,1,0. No writes occur on stall cycles. WORD_COUNT=3.
- Bad select: header 0x02000000 with NUM_MEM=2 -> ERROR=1, no MEM_WE, CORE_RESET_N=0. A following START plus a valid image reaches RUN with ERROR=0.
- Early IN_LAST: LEN=4 section with IN_LAST on word 2 -> words 1,2 written, then ERR. IN_LAST on a header -> ERR with no writes.
- Full section: LEN=1024 (header low bits 0x3FF) -> last write at address 1023, no write to address 0 after the first, and WORD_COUNT=1024.
- Reset during DATA after 2 of 4 words -> all outputs 0 immediately and asynchronously, no further MEM_WE. START in RUN -> CORE_RESET_N=0 on the next cycle and reload proceeds.
